ssd_capture: RTL and testbench
==============================

Name: ssd_capture

Overview:
Monitors a multiplexed seven-segment bus (active-low segments a..g and active-low anodes an[3:0]) and reconstructs the four hex digits being displayed. It recovers each digit value, which digits are lit, and which digits show patterns that are not hex. It sits on the receive side of a board-to-board or self-test link, driven by the team's 4-digit SSD scanning driver (100 MHz clk, ~655 µs per digit).

Parameters:
SETTLE_CYCLES, 16, consecutive stable cycles (an and segments unchanged) required before sampling a digit.
TIMEOUT_CYCLES, 524288, cycles without a sample after which a digit is declared not lit (2x a full 4-digit scan).

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-high reset.
a,b,c,d,e,f,g  input  1 each  segment lines, active-low.
an  input  4  anode lines, active-low, bit i selects digit i.
digit0..digit3  output  4 each  last decoded hex value per position.
mode  output  4  bit i = 1 when digit i was lit at its last sample and has not timed out.
invalid  output  4  bit i = 1 when the last sample of digit i was a non-hex, non-blank pattern.
frame_done  output  1  one-cycle pulse when all four positions have been sampled since the previous pulse.

Behaviour:
- All inputs (an, abcdefg) pass through a 2-flop synchronizer before any use.
- Valid selection: synchronized an has exactly one 0 bit. Any other an value (1111, multiple lows) is idle: no sampling, settle counter held at 0.
- Settle counter:
  - Cleared whenever synchronized an or segments differ from the previous cycle.
  - Increments otherwise and saturates.
  - When it reaches SETTLE_CYCLES with a valid selection and the dwell is not yet sampled, take exactly one sample for position i. The dwell is marked sampled.
  - The sampled flag clears on any an change.
- Decode of abcdefg (bit 6 = a), with 0 meaning the segment is on:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000
- Sample effects for position i:
  - Hex pattern: digit_i <= value, mode[i] <= 1, invalid[i] <= 0.
  - 1111111 (blank): mode[i] <= 0, invalid[i] <= 0, digit_i unchanged.
  - Other pattern: mode[i] <= 1, invalid[i] <= 1, digit_i unchanged.
  - All three effects register on the cycle after the sample condition.
- Latency from a bus change to the output update is 2 (sync) + SETTLE_CYCLES + 1 cycles.
- Per-position timeout counter:
  - Cleared on that position's sample; otherwise increments and saturates.
  - On reaching TIMEOUT_CYCLES: mode[i] <= 0 and invalid[i] <= 0. digit_i is retained.
  - If a sample and a timeout fall on the same cycle for the same position, the sample wins.
- frame_done:
  - A 4-bit seen mask sets bit i on each sample.
  - When the mask becomes 1111, frame_done pulses high for 1 cycle and the mask clears on that same cycle.
  - A sample landing on the clear cycle is recorded in the new mask.
- Reset (asynchronous, any time including mid-dwell):
  - Outputs: digits = 0, mode = 0000, invalid = 0000, frame_done = 0.
  - Internal state: synchronizers, settle counter, timeouts, seen mask and sampled flag are all zeroed.
  - The first sample after reset requires a full settle period.

Optional Feature:
Macro SSD_CAPTURE_GLITCH_CNT_EN.
- Defined: adds output glitch_count [7:0], reset 0. It increments (saturating at 255) each time a valid selection ends (an changes) before that dwell was sampled.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then drive an=1110, abcdefg=0010010 held 40 cycles -> digit0=2, mode=0001, invalid=0000, update exactly 2+16+1 cycles after the inputs are applied.
- Scan an 1110/1101/1011/0111 with 1, A, blank, F at 100 cycles each -> digit0=1, digit1=A, digit3=F, mode=1011; frame_done pulses once per full scan.
- Hold digit2 with pattern 1111110 -> invalid=0100, mode[2]=1, digit2 keeps its previous value.
- Toggle segments every 8 cycles on an=1110 -> no sample and no output change; with SSD_CAPTURE_GLITCH_CNT_EN, toggle an every 8 cycles 300 times -> glitch_count saturates at 255.
- Sample digit1=7, then hold an=1111 for 524288 cycles -> mode[1] falls to 0 at the timeout, digit1 stays 7.
- Assert rst mid-dwell at settle count 10 -> all outputs are 0 immediately; after release, a sample occurs only after a full settle period.

Source files
------------

// File: rtl/ssd_capture.sv
// Seven-segment bus monitor: rebuilds the four scanned hex digits, lit mask and non-hex flags.
// Optional saturating count of unsampled dwells when SSD_CAPTURE_GLITCH_CNT_EN is defined.
module ssd_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 524288
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] mode,
  output logic [3:0] invalid,
  output logic       frame_done
`ifdef SSD_CAPTURE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);

  logic [3:0]      an_s1, an_s2, an_p;
  logic [6:0]      seg_s1, seg_s2, seg_p;
  logic [SW-1:0]   settle;
  logic            sampled;
  logic [3:0]      seen;
  logic [3:0][3:0] dig;
  logic [TW-1:0]   to_cnt [4];

  logic            an_chg, chg, sel_ok, fire, blank, dec_ok;
  logic [3:0]      fire_mask, dec_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1  <= '0;
      an_s2  <= '0;
      an_p   <= '0;
      seg_s1 <= '0;
      seg_s2 <= '0;
      seg_p  <= '0;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= {a, b, c, d, e, f, g};
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  assign an_chg = (an_s2 != an_p);
  assign chg    = an_chg || (seg_s2 != seg_p);
  assign sel_ok = ($countones(~an_s2) == 1);
  // Fire on the cycle the stable run would reach SETTLE_CYCLES, so the outputs land 2+SETTLE+1 after the bus.
  assign fire      = sel_ok && !chg && !sampled && (settle == SETTLE_LAST);
  assign fire_mask = fire ? ~an_s2 : 4'b0000;
  assign blank     = (seg_s2 == 7'h7F);

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (seg_s2)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle  <= '0;
      sampled <= 1'b0;
      seen    <= '0;
    end else begin
      if (chg || !sel_ok)
        settle <= '0;
      else if (settle != SETTLE_MAX)
        settle <= settle + 1'b1;

      if (an_chg)
        sampled <= 1'b0;
      else if (fire)
        sampled <= 1'b1;

      // A sample on the pulse cycle starts the next frame's mask.
      if (&seen)
        seen <= fire_mask;
      else
        seen <= seen | fire_mask;
    end
  end

  assign frame_done = &seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig     <= '0;
      mode    <= '0;
      invalid <= '0;
      for (int i = 0; i < 4; i++) to_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fire_mask[i]) begin
          to_cnt[i] <= '0;
          if (dec_ok) begin
            dig[i]     <= dec_val;
            mode[i]    <= 1'b1;
            invalid[i] <= 1'b0;
          end else if (blank) begin
            mode[i]    <= 1'b0;
            invalid[i] <= 1'b0;
          end else begin
            mode[i]    <= 1'b1;
            invalid[i] <= 1'b1;
          end
        end else if (to_cnt[i] != TO_MAX) begin
          to_cnt[i] <= to_cnt[i] + 1'b1;
          if (to_cnt[i] == TO_LAST) begin
            mode[i]    <= 1'b0;
            invalid[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign digit0 = dig[0];
  assign digit1 = dig[1];
  assign digit2 = dig[2];
  assign digit3 = dig[3];

`ifdef SSD_CAPTURE_GLITCH_CNT_EN
  logic prev_sel_ok;
  assign prev_sel_ok = ($countones(~an_p) == 1);

  // A dwell ends unsampled when the anodes move off a valid selection before the sample fired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      glitch_count <= '0;
    else if (an_chg && prev_sel_ok && !sampled && glitch_count != 8'hFF)
      glitch_count <= glitch_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: directed scenarios plus random bus dwells checked against a dwell-level model.
module tb_ssd_capture;
  localparam int SETTLE = 16;
  localparam int TO     = 1000;
  localparam int LAT    = 2 + SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an  = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic [3:0] digit0, digit1, digit2, digit3, mode, invalid;
  logic       frame_done;
`ifdef SSD_CAPTURE_GLITCH_CNT_EN
  logic [7:0] glitch_count;
`endif

  always #5 clk = ~clk;

  ssd_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .an(an),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .mode(mode), .invalid(invalid), .frame_done(frame_done)
`ifdef SSD_CAPTURE_GLITCH_CNT_EN
    , .glitch_count(glitch_count)
`endif
  );

  logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int ncmp = 0, nfail = 0;
  int frames_obs = 0;
  always @(negedge clk) if (frame_done === 1'b1) frames_obs++;

  // Reference model: one entry per dwell, not per cycle.
  int         cyc = 0;
  logic [3:0] cur_an = 4'h0;
  logic [6:0] cur_seg = 7'h00;
  int         stab = 0;
  bit         dsamp = 0;
  logic [3:0] m_dig [4];
  bit         m_lit [4];
  bit         m_inv [4];
  int         m_sedge [4];
  logic [3:0] m_seen = 4'h0;
  int         m_frames = 0;
  int         m_gc = 0;

  function automatic bit one_sel(logic [3:0] x);
    return $countones(~x) == 1;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample_model();
    int p = 0;
    bit hit = 0;
    logic [3:0] v = 4'h0;
    for (int i = 0; i < 4; i++) if (!cur_an[i]) p = i;
    for (int h = 0; h < 16; h++) if (HEX[h] == cur_seg) begin hit = 1; v = h[3:0]; end
    if (hit) begin m_dig[p] = v; m_lit[p] = 1; m_inv[p] = 0; end
    else if (cur_seg == 7'h7F) begin m_lit[p] = 0; m_inv[p] = 0; end
    else begin m_lit[p] = 1; m_inv[p] = 1; end
    m_sedge[p] = stab + LAT;
    m_seen[p] = 1'b1;
    if (m_seen == 4'hF) begin m_frames++; m_seen = 4'h0; end
    dsamp = 1;
  endtask

  task automatic drive(logic [3:0] nan, logic [6:0] nseg);
    if (nan == cur_an && nseg == cur_seg) return;
    if (one_sel(cur_an) && !dsamp && cyc - stab >= LAT - 2) sample_model();
    if (nan != cur_an) begin
      if (one_sel(cur_an) && !dsamp && m_gc < 255) m_gc++;
      dsamp = 0;
    end
    cur_an = nan; cur_seg = nseg; stab = cyc;
    an = nan; seg = nseg;
  endtask

  task automatic run(int n);
    repeat (n) begin @(posedge clk); cyc++; end
    @(negedge clk); #1;
    if (one_sel(cur_an) && !dsamp && cyc - stab >= LAT) sample_model();
  endtask

  task automatic check(string tag);
    logic [3:0] dg [4];
    logic [3:0] em, ei;
    dg[0] = digit0; dg[1] = digit1; dg[2] = digit2; dg[3] = digit3;
    for (int i = 0; i < 4; i++) begin
      em[i] = m_lit[i] && (cyc - m_sedge[i] < TO);
      ei[i] = m_inv[i] && (cyc - m_sedge[i] < TO);
      cmp($sformatf("%s_digit%0d", tag, i), 32'(dg[i]), 32'(m_dig[i]));
    end
    cmp({tag, "_mode"}, 32'(mode), 32'(em));
    cmp({tag, "_invalid"}, 32'(invalid), 32'(ei));
    cmp({tag, "_frames"}, frames_obs, m_frames);
`ifdef SSD_CAPTURE_GLITCH_CNT_EN
    cmp({tag, "_glitch"}, 32'(glitch_count), m_gc);
`endif
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1; #1;
    cmp({tag, "_d0"}, 32'(digit0), 0);
    cmp({tag, "_d1"}, 32'(digit1), 0);
    cmp({tag, "_d2"}, 32'(digit2), 0);
    cmp({tag, "_d3"}, 32'(digit3), 0);
    cmp({tag, "_mode"}, 32'(mode), 0);
    cmp({tag, "_inv"}, 32'(invalid), 0);
    cmp({tag, "_fd"}, 32'(frame_done), 0);
`ifdef SSD_CAPTURE_GLITCH_CNT_EN
    cmp({tag, "_gc"}, 32'(glitch_count), 0);
`endif
    for (int i = 0; i < 4; i++) begin m_dig[i] = 0; m_lit[i] = 0; m_inv[i] = 0; m_sedge[i] = 0; end
    cur_an = 4'h0; cur_seg = 7'h00; dsamp = 0; m_seen = 4'h0; m_gc = 0;
    run(3);
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] scan_pat [4];
    logic [3:0] na;
    logic [6:0] ns;
    int n;
    scan_pat[0] = HEX[1]; scan_pat[1] = HEX[10]; scan_pat[2] = 7'h7F; scan_pat[3] = HEX[15];

    @(negedge clk); #1;
    do_reset("reset0");

    // Single digit, exact latency
    drive(4'b1110, 7'b0010010);
    run(LAT - 1); check("lat_before");
    run(1);       check("lat_at");
    cmp("lat_digit0", 32'(digit0), 2);
    cmp("lat_mode", 32'(mode), 32'b0001);
    run(21);      check("lat_hold");

    // Two full scans
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 4; p++) begin
        drive(~(4'b0001 << p), scan_pat[p]);
        run(100);
        check($sformatf("scan%0d_%0d", s, p));
      end
    cmp("scan_mode", 32'(mode), 32'b1011);

    // Non-hex pattern on position 2
    drive(4'b1011, 7'b1111110);
    run(40); check("nonhex");

    // Segments toggling faster than the settle window
    for (int k = 0; k < 10; k++) begin
      drive(4'b1110, (k % 2) ? HEX[5] : HEX[6]);
      run(8);
    end
    check("segtoggle");

    // Anodes toggling faster than the settle window
    for (int k = 0; k < 300; k++) begin
      drive((k % 2) ? 4'b1101 : 4'b1110, HEX[3]);
      run(8);
      if (k == 150) check("antoggle_mid");
    end
    check("antoggle_end");

    // Timeout of position 1 at the exact boundary
    drive(4'b1101, HEX[7]);
    run(30); check("to_sample");
    drive(4'b1111, 7'h7F);
    run(TO - 12); check("to_before");
    run(1);       check("to_after");
    cmp("to_digit1", 32'(digit1), 7);

    // Reset in the middle of a dwell
    drive(4'b1110, HEX[12]);
    run(13);
    do_reset("reset_mid");
    drive(4'b1110, HEX[12]);
    run(LAT - 1); check("rst_before");
    run(1);       check("rst_at");
    run(20);      check("rst_hold");

    // Random dwells
    for (int k = 0; k < 80; k++) begin
      n = $urandom_range(0, 9);
      if (n < 8) na = ~(4'b0001 << (n % 4));
      else if (n == 8) na = 4'b1111;
      else na = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 3);
      if (n < 2) ns = HEX[$urandom_range(0, 15)];
      else if (n == 2) ns = 7'h7F;
      else ns = 7'($urandom_range(0, 127));
      drive(na, ns);
      run(($urandom_range(0, 1) == 1) ? $urandom_range(3, 14) : $urandom_range(20, 60));
      check($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
